i2c_txn_capture: RTL and testbench
==================================

// Module: i2c_txn_capture
// PURPOSE
//  Synthesizable I2C bus capture/responder in front of the ncsu-based i2c monitor/agent.
//  Samples SCL/SDA, detects START/STOP, deserializes address and data bytes, and ACKs
//  address/write bytes addressed to SLAVE_ADDR. Emits byte-level records through a FIFO
//  with valid/ready to the monitor, which builds i2c transactions from them.
// PARAMETERS
//  SLAVE_ADDR   7'h22  7-bit address this block ACKs
//  FIFO_DEPTH   8      record FIFO entries, power of 2, >=2
//  SYNC_STAGES  2      synchronizer flops on scl/sda, >=2
// PORTS
//  clk          in   1   system clock; all state on rising edge
//  rst          in   1   asynchronous, active-low reset
//  scl          in   1   raw I2C clock (async to clk)
//  sda          in   1   raw I2C data (async to clk)
//  sda_pull     out  1   1 = drive SDA low (open-drain ACK)
//  rec_valid    out  1   FIFO head valid
//  rec_ready    in   1   consumer accepts head when rec_valid&rec_ready
//  rec          out  11  head record {kind[1:0], data[7:0], ack}
//  overflow     out  1   sticky: a record was dropped on a full FIFO
//  clr_overflow in   1   clears overflow (set wins if same cycle)
// BEHAVIOUR
//  Reset: all FIFOs/state cleared, state=IDLE; sda_pull=0, rec_valid=0, rec=0, overflow=0.
//   sda_pull deasserts asynchronously on reset assertion.
//  Edges: detected on synchronized scl_s/sda_s vs. previous sample. START = sda_s fall
//   while scl_s=1; STOP = sda_s rise while scl_s=1. SDA sampled on scl_s rise only.
//  kind: 2'd0 ADDR, 2'd1 DATA, 2'd2 STOP, 2'd3 RSVD (never emitted). ack = sampled 9th bit
//   (0 = ACK). ADDR record data = {addr[6:0], rw}. STOP record data=0, ack=1.
//  FSM: IDLE -START-> ADDR; ADDR: shift 8 bits MSB first, on 8th scl rise -> ADDR_ACK;
//   ADDR_ACK: on 9th scl rise push ADDR record, -> DATA; DATA: 8 bits -> DATA_ACK;
//   DATA_ACK: 9th scl rise push DATA record, -> DATA. STOP from any state -> push STOP,
//   -> IDLE. START in any non-IDLE state (repeated start) -> ADDR, no STOP record.
//  matched flag set when addr[6:0]==SLAVE_ADDR at ADDR_ACK entry; cleared at START/STOP.
//  ACK drive: sda_pull=1 from the scl_s fall after the 8th bit to the scl_s fall after
//   the 9th bit, only if matched and (byte is address, or data byte with rw=0).
//   Never drives on read-direction data bytes or unmatched addresses (monitor only).
//  Bytes recorded for all addresses, matched or not.
//  Partial byte (<9 bits) at STOP/START: discarded, bit counter reset.
//  Latency: record pushed the cycle after the 9th synchronized scl rise; rec_valid
//   rises next cycle when FIFO was empty (SYNC_STAGES+2 clk after raw edge).
//  FIFO: push when not full, or full with pop in same cycle; otherwise record dropped and
//   overflow set. Pop on rec_valid&rec_ready. rec is registered head, stable while
//   rec_valid&!rec_ready. Pointers wrap at FIFO_DEPTH with one extra bit for full/empty.
//  STOP and 9th-bit push never coincide (distinct scl phases); no push arbitration needed.
// STRUCTURE
//  Package i2c_cap_pkg: typedef enum logic[1:0] rec_kind_e; typedef struct packed
//   {rec_kind_e kind; logic[7:0] data; logic ack;} i2c_rec_t; typedef enum cap_state_e
//   {IDLE,ADDR,ADDR_ACK,DATA,DATA_ACK}; localparam REC_W=11.
//  Sub-module i2c_cap_fifo (sync FIFO of i2c_rec_t, DEPTH param, full/empty, push/pop).
//  Top holds synchronizers, edge detect, FSM, shift reg, bit counter, ACK driver.
// TESTING
//  1 Write 0x22 W, bytes 0xA5,0x3C, STOP -> recs {ADDR,0x44,0},{DATA,0xA5,0},{DATA,0x3C,0},
//    {STOP,0,1}; sda_pull asserted exactly during the three 9th-bit windows.
//  2 Addr 0x23 W, byte 0x11 -> {ADDR,0x46,1},{DATA,0x11,1},STOP; sda_pull never 1.
//  3 Read 0x22 R, master ACKs 0x5A then NACKs 0xFF -> {ADDR,0x45,0},{DATA,0x5A,0},
//    {DATA,0xFF,1},STOP; sda_pull only on address ACK.
//  4 Repeated START after 4 data bits, new addr 0x22 R -> partial byte dropped, no STOP
//    record, next rec is {ADDR,0x45,0}.
//  5 rec_ready=0, 10 records with FIFO_DEPTH=8 -> first 8 kept in order, overflow=1;
//    clr_overflow clears it; simultaneous push/pop on full accepts push.
//  6 rst low mid-DATA_ACK with sda_pull=1 -> sda_pull=0 same cycle, rec_valid=0,
//    FSM IDLE; next START captured normally.

Source files
------------

// File: rtl/i2c_cap_pkg.sv
// Shared types for the I2C transaction capture block: record layout, record kinds
// and capture FSM states.
package i2c_cap_pkg;

    localparam int REC_W = 11;

    typedef enum logic [1:0] {
        REC_ADDR = 2'd0,
        REC_DATA = 2'd1,
        REC_STOP = 2'd2,
        REC_RSVD = 2'd3
    } rec_kind_e;

    typedef struct packed {
        rec_kind_e  kind;
        logic [7:0] data;
        logic       ack;
    } i2c_rec_t;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        DATA,
        DATA_ACK
    } cap_state_e;

    function automatic i2c_rec_t mk_rec(rec_kind_e kind, logic [7:0] data, logic ack);
        i2c_rec_t r;
        r.kind = kind;
        r.data = data;
        r.ack  = ack;
        return r;
    endfunction

endpackage

// File: rtl/i2c_cap_fifo.sv
// Synchronous record FIFO. A push into a full FIFO is still accepted when the head
// is popped in the same cycle; otherwise it is dropped and flagged on o_drop.
module i2c_cap_fifo
    import i2c_cap_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [REC_W-1:0] i_rec,
    input  logic             i_pop,
    output logic [REC_W-1:0] o_head,
    output logic             o_empty,
    output logic             o_drop
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [REC_W-1:0] r_mem [DEPTH];
    logic             w_full;
    logic             w_pop;
    logic             w_push_ok;

    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign o_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_pop     = i_pop && !o_empty;
    assign w_push_ok = i_push && (!w_full || w_pop);
    assign o_drop    = i_push && !w_push_ok;
    assign o_head    = r_mem[r_rd_ptr[AW-1:0]];

    // Storage; cleared on reset so the head reads zero while empty after reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_push_ok) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_rec;
        end
    end

    // Read/write pointers with one extra wrap bit to tell full from empty.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/i2c_txn_capture.sv
// I2C bus capture/responder: synchronizes SCL/SDA, tracks START/STOP and byte
// framing, ACKs bytes addressed to SLAVE_ADDR and queues byte-level records.
//
//  state    | meaning
//  ---------+----------------------------------------------
//  IDLE     | bus free, waiting for START
//  ADDR     | shifting in the 7-bit address and R/W bit
//  ADDR_ACK | address byte complete, waiting for 9th bit
//  DATA     | shifting in a data byte
//  DATA_ACK | data byte complete, waiting for 9th bit
module i2c_txn_capture
    import i2c_cap_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h22,
    parameter int         FIFO_DEPTH  = 8,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_scl,
    input  logic             i_sda,
    output logic             o_sda_pull,
    output logic             o_rec_valid,
    input  logic             i_rec_ready,
    output logic [REC_W-1:0] o_rec,
    output logic             o_overflow,
    input  logic             i_clr_overflow
);

    logic [SYNC_STAGES-1:0] r_scl_sync;
    logic [SYNC_STAGES-1:0] r_sda_sync;
    logic                   r_scl_d;
    logic                   r_sda_d;
    cap_state_e             r_state;
    cap_state_e             w_state_nxt;
    logic [7:0]             r_shift;
    logic [2:0]             r_bit_cnt;
    logic                   r_matched;
    logic                   r_rw;
    logic                   r_sda_pull;
    logic                   r_push;
    i2c_rec_t               r_push_rec;
    logic                   r_overflow;
    logic                   w_push;
    i2c_rec_t               w_push_rec;
    logic                   w_scl_s;
    logic                   w_sda_s;
    logic                   w_scl_rise;
    logic                   w_scl_fall;
    logic                   w_start;
    logic                   w_stop;
    logic [7:0]             w_shift_nxt;
    logic                   w_empty;
    logic                   w_drop;

    assign w_scl_s     = r_scl_sync[SYNC_STAGES-1];
    assign w_sda_s     = r_sda_sync[SYNC_STAGES-1];
    assign w_scl_rise  = w_scl_s && !r_scl_d;
    assign w_scl_fall  = !w_scl_s && r_scl_d;
    assign w_start     = w_scl_s && r_sda_d && !w_sda_s;
    assign w_stop      = w_scl_s && !r_sda_d && w_sda_s;
    assign w_shift_nxt = {r_shift[6:0], w_sda_s};

    // Synchronize the raw bus lines and keep the previous sample for edge detection.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_scl_sync <= '1;
            r_sda_sync <= '1;
            r_scl_d    <= 1'b1;
            r_sda_d    <= 1'b1;
        end else begin
            r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
            r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
            r_scl_d    <= w_scl_s;
            r_sda_d    <= w_sda_s;
        end
    end

    // Capture FSM state register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next state and record push; STOP wins, START restarts framing from any state.
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_push_rec  = '0;
        if (w_stop) begin
            w_state_nxt = IDLE;
            w_push      = 1'b1;
            w_push_rec  = mk_rec(REC_STOP, 8'h00, 1'b1);
        end else if (w_start) begin
            w_state_nxt = ADDR;
        end else if (w_scl_rise) begin
            case (r_state)
                ADDR:     if (r_bit_cnt == 3'd7) w_state_nxt = ADDR_ACK;
                ADDR_ACK: begin
                    w_state_nxt = DATA;
                    w_push      = 1'b1;
                    w_push_rec  = mk_rec(REC_ADDR, r_shift, w_sda_s);
                end
                DATA:     if (r_bit_cnt == 3'd7) w_state_nxt = DATA_ACK;
                DATA_ACK: begin
                    w_state_nxt = DATA;
                    w_push      = 1'b1;
                    w_push_rec  = mk_rec(REC_DATA, r_shift, w_sda_s);
                end
                default:  ;
            endcase
        end
    end

    // Shift register, bit counter, address match and the open-drain ACK driver.
    // The ACK window runs from the SCL fall after bit 8 to the SCL fall after bit 9.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_matched  <= 1'b0;
            r_rw       <= 1'b0;
            r_sda_pull <= 1'b0;
            r_push     <= 1'b0;
            r_push_rec <= '0;
        end else begin
            r_push     <= w_push;
            r_push_rec <= w_push_rec;
            if (w_start || w_stop) begin
                r_bit_cnt  <= '0;
                r_matched  <= 1'b0;
                r_sda_pull <= 1'b0;
            end else begin
                if (w_scl_rise && (r_state == ADDR || r_state == DATA)) begin
                    r_shift   <= w_shift_nxt;
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                    if (r_state == ADDR && r_bit_cnt == 3'd7) begin
                        r_matched <= (w_shift_nxt[7:1] == SLAVE_ADDR);
                        r_rw      <= w_shift_nxt[0];
                    end
                end
                if (w_scl_fall) begin
                    r_sda_pull <= r_matched &&
                                  (r_state == ADDR_ACK || (r_state == DATA_ACK && !r_rw));
                end
            end
        end
    end

    i2c_cap_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (r_push),
        .i_rec   (r_push_rec),
        .i_pop   (i_rec_ready),
        .o_head  (o_rec),
        .o_empty (w_empty),
        .o_drop  (w_drop)
    );

    // Sticky overflow; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)            r_overflow <= 1'b0;
        else if (w_drop)         r_overflow <= 1'b1;
        else if (i_clr_overflow) r_overflow <= 1'b0;
    end

    assign o_sda_pull  = r_sda_pull;
    assign o_rec_valid = !w_empty;
    assign o_overflow  = r_overflow;

endmodule

// File: tb/tb_i2c_txn_capture.sv
// Directed bench for i2c_txn_capture: a bit-banged I2C master on a wired-AND SDA
// line, with a record scoreboard of hand-computed expected records.
module tb_i2c_txn_capture;

    localparam int Q = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        scl = 1'b1;
    logic        sda_m = 1'b1;
    logic        rec_ready = 1'b1;
    logic        clr_ovf = 1'b0;
    logic        sda_pull;
    logic        rec_valid;
    logic        overflow;
    logic [10:0] rec;
    logic        sda_line;

    int          n_chk = 0;
    int          n_pass = 0;
    logic [10:0] obs_q[$];
    logic [10:0] exp_q[$];
    int          obs_base = 0;
    int          pull_rises = 0;
    int          pull_base = 0;
    logic        pull_prev = 1'b0;

    assign sda_line = sda_m & ~sda_pull;

    always #5 clk = ~clk;

    i2c_txn_capture dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_scl          (scl),
        .i_sda          (sda_line),
        .o_sda_pull     (sda_pull),
        .o_rec_valid    (rec_valid),
        .i_rec_ready    (rec_ready),
        .o_rec          (rec),
        .o_overflow     (overflow),
        .i_clr_overflow (clr_ovf)
    );

    // Collect every accepted record and count ACK-drive assertions.
    always @(posedge clk) begin
        if (rec_valid && rec_ready) obs_q.push_back(rec);
        if (sda_pull && !pull_prev) pull_rises++;
        pull_prev <= sda_pull;
    end

    task automatic wq(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [10:0] rec_of(input logic [1:0] k, input logic [7:0] d, input logic a);
        return {k, d, a};
    endfunction

    task automatic i2c_start();
        wq(Q); sda_m = 1'b0; wq(Q); scl = 1'b0;
    endtask

    task automatic i2c_rstart();
        wq(Q); sda_m = 1'b1; wq(Q); scl = 1'b1; wq(Q); sda_m = 1'b0; wq(Q); scl = 1'b0;
    endtask

    task automatic i2c_stop();
        wq(Q); sda_m = 1'b0; wq(Q); scl = 1'b1; wq(Q); sda_m = 1'b1; wq(Q);
    endtask

    task automatic send_bit(input logic b, output logic pull_hi);
        wq(Q); sda_m = b; wq(Q); scl = 1'b1; wq(Q); pull_hi = sda_pull; wq(Q); scl = 1'b0;
    endtask

    // Eight data bits then the 9th bit; optionally pulses rec_ready for exactly the
    // cycle in which the 9th-bit record is written into the FIFO.
    task automatic send_byte(input string tag, input logic [7:0] d, input logic ack_drive,
                             input logic exp_pull, input bit pop_on_ack);
        logic p;
        logic any;
        any = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            send_bit(d[i], p);
            any |= p;
        end
        chk({tag, "_pull_bits"}, any, 1'b0);
        wq(Q); sda_m = ack_drive; wq(Q); scl = 1'b1;
        if (pop_on_ack) begin
            wq(3); rec_ready = 1'b1; wq(1); rec_ready = 1'b0; wq(Q - 4);
        end else begin
            wq(Q);
        end
        chk({tag, "_pull_ack"}, sda_pull, exp_pull);
        wq(Q); scl = 1'b0;
    endtask

    task automatic compare_recs(input string tag);
        logic [10:0] got;
        wq(20);
        chk({tag, "_count"}, obs_q.size() - obs_base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (obs_base + i < obs_q.size()) ? obs_q[obs_base + i] : 11'h7FF;
            chk($sformatf("%s_rec%0d", tag, i), got, exp_q[i]);
        end
        exp_q.delete();
        obs_base = obs_q.size();
    endtask

    initial begin
        logic p;

        // Reset values
        wq(3);
        chk("rst_pull", sda_pull, 1'b0);
        chk("rst_valid", rec_valid, 1'b0);
        chk("rst_rec", rec, 11'h000);
        chk("rst_ovf", overflow, 1'b0);
        rst_n = 1'b1;
        wq(5);

        // 1: matched write, two bytes
        obs_base  = obs_q.size();
        pull_base = pull_rises;
        i2c_start();
        send_byte("t1_addr", 8'h44, 1'b1, 1'b1, 0);
        send_byte("t1_d0", 8'hA5, 1'b1, 1'b1, 0);
        send_byte("t1_d1", 8'h3C, 1'b1, 1'b1, 0);
        i2c_stop();
        exp_q.push_back(rec_of(2'd0, 8'h44, 1'b0));
        exp_q.push_back(rec_of(2'd1, 8'hA5, 1'b0));
        exp_q.push_back(rec_of(2'd1, 8'h3C, 1'b0));
        exp_q.push_back(rec_of(2'd2, 8'h00, 1'b1));
        compare_recs("t1");
        chk("t1_pull_rises", pull_rises - pull_base, 3);

        // 2: unmatched address, monitor only
        pull_base = pull_rises;
        i2c_start();
        send_byte("t2_addr", 8'h46, 1'b1, 1'b0, 0);
        send_byte("t2_d0", 8'h11, 1'b1, 1'b0, 0);
        i2c_stop();
        exp_q.push_back(rec_of(2'd0, 8'h46, 1'b1));
        exp_q.push_back(rec_of(2'd1, 8'h11, 1'b1));
        exp_q.push_back(rec_of(2'd2, 8'h00, 1'b1));
        compare_recs("t2");
        chk("t2_pull_rises", pull_rises - pull_base, 0);

        // 3: matched read, master ACK then NACK
        pull_base = pull_rises;
        i2c_start();
        send_byte("t3_addr", 8'h45, 1'b1, 1'b1, 0);
        send_byte("t3_d0", 8'h5A, 1'b0, 1'b0, 0);
        send_byte("t3_d1", 8'hFF, 1'b1, 1'b0, 0);
        i2c_stop();
        exp_q.push_back(rec_of(2'd0, 8'h45, 1'b0));
        exp_q.push_back(rec_of(2'd1, 8'h5A, 1'b0));
        exp_q.push_back(rec_of(2'd1, 8'hFF, 1'b1));
        exp_q.push_back(rec_of(2'd2, 8'h00, 1'b1));
        compare_recs("t3");
        chk("t3_pull_rises", pull_rises - pull_base, 1);

        // 4: repeated START after a partial data byte
        i2c_start();
        send_byte("t4_addr", 8'h44, 1'b1, 1'b1, 0);
        send_bit(1'b1, p);
        send_bit(1'b0, p);
        send_bit(1'b1, p);
        send_bit(1'b1, p);
        i2c_rstart();
        send_byte("t4_addr2", 8'h45, 1'b1, 1'b1, 0);
        i2c_stop();
        exp_q.push_back(rec_of(2'd0, 8'h44, 1'b0));
        exp_q.push_back(rec_of(2'd0, 8'h45, 1'b0));
        exp_q.push_back(rec_of(2'd2, 8'h00, 1'b1));
        compare_recs("t4");

        // 5: FIFO full, overflow, clear, push+pop on full
        rec_ready = 1'b0;
        i2c_start();
        send_byte("t5_addr", 8'h44, 1'b1, 1'b1, 0);
        for (int i = 0; i < 8; i++) send_byte("t5_d", 8'h10 + 8'(i), 1'b1, 1'b1, 0);
        i2c_stop();
        wq(20);
        chk("t5_ovf_set", overflow, 1'b1);
        chk("t5_valid", rec_valid, 1'b1);
        chk("t5_head", rec, rec_of(2'd0, 8'h44, 1'b0));
        clr_ovf = 1'b1; wq(1); clr_ovf = 1'b0; wq(1);
        chk("t5_ovf_clr", overflow, 1'b0);
        i2c_start();
        send_byte("t5_addr2", 8'h44, 1'b1, 1'b1, 1);
        wq(4);
        chk("t5_ovf_pushpop", overflow, 1'b0);
        rec_ready = 1'b1;
        i2c_stop();
        exp_q.push_back(rec_of(2'd0, 8'h44, 1'b0));
        for (int i = 0; i < 7; i++) exp_q.push_back(rec_of(2'd1, 8'h10 + 8'(i), 1'b0));
        exp_q.push_back(rec_of(2'd0, 8'h44, 1'b0));
        exp_q.push_back(rec_of(2'd2, 8'h00, 1'b1));
        compare_recs("t5");

        // 6: reset during a data ACK window, then a normal transaction
        i2c_start();
        send_byte("t6_addr", 8'h44, 1'b1, 1'b1, 0);
        for (int i = 7; i >= 0; i--) send_bit(i[0], p);
        wq(Q); sda_m = 1'b1; wq(Q);
        chk("t6_pull_pre", sda_pull, 1'b1);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_rst_pull", sda_pull, 1'b0);
        chk("t6_rst_valid", rec_valid, 1'b0);
        chk("t6_rst_rec", rec, 11'h000);
        scl = 1'b1; sda_m = 1'b1;
        wq(4);
        rst_n = 1'b1;
        wq(4);
        obs_base = obs_q.size();
        i2c_start();
        send_byte("t6_addr2", 8'h45, 1'b1, 1'b1, 0);
        i2c_stop();
        exp_q.push_back(rec_of(2'd0, 8'h45, 1'b0));
        exp_q.push_back(rec_of(2'd2, 8'h00, 1'b1));
        compare_recs("t6");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
